// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter that shares one bin2bcd converter between N requesters.
// A grant issues one conversion; the converter is watched by a timeout counter.
module bcd_conv_arbiter #(
    parameter int N       = 4,
    parameter int W       = 14,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] bin_in,
    output logic [N-1:0]   ack,
    output logic [23:0]    result,
    output logic           err,
    output logic           busy,
    output logic           conv_start,
    output logic [W-1:0]   conv_bin,
    input  logic           conv_ready,
    input  logic           conv_done_tick,
    input  logic [23:0]    conv_dig
);

    // state   | meaning
    // IDLE    | arbitrate among pending requests
    // ISSUE   | operand latched, start pulse once converter is ready
    // WAIT    | conversion running, timeout counter active
    // DELIVER | ack (and err on timeout) to the granted requester
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_DELIVER = 2'd3
    } state_t;

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   ptr_nxt;
    logic [CW-1:0]   wait_cnt;
    logic            to_flag;
    logic            any_req;
    logic            timeout_hit;

    // Scan downward so the lowest offset from ptr is the one that sticks.
    always_comb begin
        any_req = |req;
        pick    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                pick = IW'((int'(ptr) + k) % N);
            end
        end
    end

    always_comb begin
        if (int'(gnt_idx) == N - 1) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = gnt_idx + 1'b1;
        end
    end

    assign timeout_hit = (state == S_WAIT) && !conv_done_tick &&
                         (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (any_req) state_nxt = S_ISSUE;
            S_ISSUE:   if (conv_ready) state_nxt = S_WAIT;
            S_WAIT:    if (conv_done_tick || timeout_hit) state_nxt = S_DELIVER;
            S_DELIVER: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        conv_start = (state == S_ISSUE) && conv_ready;
        ack        = '0;
        err        = 1'b0;
        if (state == S_DELIVER) begin
            ack[gnt_idx] = 1'b1;
            err          = to_flag;
        end
    end

    // A timeout forces result to zero one cycle early so it is valid with ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            gnt_idx  <= '0;
            wait_cnt <= '0;
            conv_bin <= '0;
            result   <= '0;
            to_flag  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        gnt_idx  <= pick;
                        conv_bin <= bin_in[int'(pick)*W +: W];
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    to_flag  <= 1'b0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (conv_done_tick) begin
                        result <= conv_dig;
                    end else if (timeout_hit) begin
                        result  <= '0;
                        to_flag <= 1'b1;
                    end
                end
                S_DELIVER: begin
                    ptr <= ptr_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed plus randomized bench for bcd_conv_arbiter; the converter and the
// round-robin arbitration are modelled behaviourally inside the bench.
module tb_bcd_conv_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [55:0] bin_in;
    logic [3:0]  ack;
    logic [23:0] result;
    logic        err;
    logic        busy;
    logic        conv_start;
    logic [13:0] conv_bin;
    logic        conv_ready;
    logic        conv_done_tick;
    logic [23:0] conv_dig;

    int          tests = 0;
    int          fails = 0;
    int          model_ptr = 0;
    logic [13:0] ops [4];

    bcd_conv_arbiter #(.N(4), .W(14), .TIMEOUT(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .bin_in         (bin_in),
        .ack            (ack),
        .result         (result),
        .err            (err),
        .busy           (busy),
        .conv_start     (conv_start),
        .conv_bin       (conv_bin),
        .conv_ready     (conv_ready),
        .conv_done_tick (conv_done_tick),
        .conv_dig       (conv_dig)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic int model_pick(input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(model_ptr + k) % 4]) return (model_ptr + k) % 4;
        end
        return 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [13:0] v);
        ops[i] = v;
        bin_in[i*14 +: 14] = v;
    endtask

    task automatic do_reset();
        conv_done_tick = 1'b0;
        req = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", conv_start, 0);
        chk("rst_result", result, 0);
        chk("rst_convbin", conv_bin, 0);
        chk("rst_err", err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        model_ptr = 0;
        tick();
    endtask

    // One full transaction: start, converter completion (or hang), delivery.
    task automatic serve(input int idx, input int delay, input bit hang, output int lat);
        int c;
        lat = 0;
        while (!conv_start && lat < 300) begin
            tick();
            lat++;
        end
        chk("start_seen", conv_start, 1);
        chk("conv_bin", conv_bin, ops[idx]);
        tick();
        chk("start_single", conv_start, 0);
        if (!hang) begin
            repeat (delay - 1) tick();
            conv_done_tick = 1'b1;
            conv_dig = to_bcd(int'(ops[idx]));
            tick();
            conv_done_tick = 1'b0;
            conv_dig = 24'hABCDEF;
        end else begin
            c = 0;
            while (ack == 0 && c < 100) begin
                tick();
                c++;
            end
            chk("timeout_cycles", c, 64);
        end
        chk("ack", ack, 32'(1) << idx);
        chk("result", result, hang ? 0 : to_bcd(int'(ops[idx])));
        chk("err", err, hang ? 1 : 0);
        req[idx] = 1'b0;
        model_ptr = (idx + 1) % 4;
        tick();
        chk("ack_pulse", ack, 0);
        chk("err_pulse", err, 0);
    endtask

    initial begin
        int lat;
        int exp_idx;
        rst_n = 1'b1;
        req = '0;
        bin_in = '0;
        conv_ready = 1'b1;
        conv_done_tick = 1'b0;
        conv_dig = 24'hABCDEF;
        for (int i = 0; i < 4; i++) ops[i] = '0;
        tick();
        do_reset();

        // single request, fixed operand
        set_op(2, 14'd9999);
        req = 4'b0100;
        serve(2, 20, 1'b0, lat);
        chk("start_latency", lat, 1);
        chk("result_9999", result, 24'h009999);

        // contention from ptr=0
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 14'($urandom_range(0, 16383)));
        req = 4'b1111;
        for (int k = 0; k < 4; k++) serve(k, $urandom_range(1, 30), 1'b0, lat);

        // fairness between requesters 0 and 3
        set_op(0, 14'($urandom_range(0, 16383)));
        set_op(3, 14'($urandom_range(0, 16383)));
        req = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            exp_idx = (k % 2 == 0) ? 0 : 3;
            serve(exp_idx, $urandom_range(1, 20), 1'b0, lat);
            set_op(exp_idx, 14'($urandom_range(0, 16383)));
            req[exp_idx] = 1'b1;
        end
        req = '0;
        tick();

        // converter not ready for 10 cycles
        conv_ready = 1'b0;
        set_op(1, 14'($urandom_range(0, 16383)));
        req = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("nr_start", conv_start, 0);
            chk("nr_busy", busy, 1);
        end
        conv_ready = 1'b1;
        #1;
        chk("nr_start_rise", conv_start, 1);
        serve(1, 7, 1'b0, lat);

        // timeout, then the next request is served normally
        set_op(2, 14'd1234);
        req = 4'b0100;
        serve(2, 0, 1'b1, lat);
        set_op(1, 14'($urandom_range(0, 16383)));
        req = 4'b0010;
        serve(model_pick(req), 5, 1'b0, lat);

        // reset while waiting on the converter
        set_op(2, 14'($urandom_range(0, 16383)));
        set_op(3, 14'($urandom_range(0, 16383)));
        req = 4'b1100;
        lat = 0;
        while (!conv_start && lat < 300) begin
            tick();
            lat++;
        end
        chk("rw_conv_bin", conv_bin, ops[2]);
        repeat (5) tick();
        rst_n = 1'b0;
        req = '0;
        #1;
        chk("rw_ack", ack, 0);
        chk("rw_busy", busy, 0);
        chk("rw_start", conv_start, 0);
        chk("rw_convbin", conv_bin, 0);
        chk("rw_result", result, 0);
        tick();
        tick();
        rst_n = 1'b1;
        model_ptr = 0;
        tick();
        conv_done_tick = 1'b1;
        conv_dig = 24'h123456;
        tick();
        conv_done_tick = 1'b0;
        chk("rw_stray_ack", ack, 0);
        chk("rw_stray_busy", busy, 0);
        chk("rw_stray_result", result, 0);
        set_op(0, 14'($urandom_range(0, 16383)));
        set_op(3, 14'($urandom_range(0, 16383)));
        req = 4'b1001;
        serve(0, 9, 1'b0, lat);
        serve(3, 9, 1'b0, lat);

        // randomized traffic
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    set_op(i, 14'($urandom_range(0, 16383)));
                    req[i] = 1'b1;
                end
            end
            if (req == 0) begin
                exp_idx = $urandom_range(0, 3);
                set_op(exp_idx, 14'($urandom_range(0, 16383)));
                req[exp_idx] = 1'b1;
            end
            serve(model_pick(req), $urandom_range(1, 40), 1'b0, lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
